// File: rtl/pipelined_cla_adder_if.sv
// Handshake and operand/result bundle for the pipelined CLA add/subtract unit.
interface pipelined_cla_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c0;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             Cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  // Execute-stage control: supplies operands, consumes results
  modport master (
    output in_valid, x, y, c0, sub, out_ready,
    input  in_ready, out_valid, sum, Cout, ovf, zero, neg
  );

  // Adder side
  modport slave (
    input  in_valid, x, y, c0, sub, out_ready,
    output in_ready, out_valid, sum, Cout, ovf, zero, neg
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/subtract unit.
// Each pipeline stage resolves WIDTH/STAGES result bits with a chain of
// BLOCK-bit lookahead groups; the slice carry is registered between stages.
// Per-stage valid bits give a stall-capable pipeline with bubble collapse.

// One lookahead group: all internal carries derived directly from p/g/ci.
module cla_block #(parameter int BLOCK = 4) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             cm   // carry into the group MSB (for overflow)
);
  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             gacc;
  logic             pacc;

  assign p = a ^ b;
  assign g = a & b;

  // Carry i+1 = OR over j of g[j] gated by the propagate run p[i:j+1], plus ci gated by p[i:0]
  always_comb begin
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      gacc = g[i];
      pacc = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gacc = gacc | (pacc & g[j]);
        pacc = pacc & p[j];
      end
      c[i+1] = gacc | (pacc & ci);
    end
  end

  assign s  = p ^ c[BLOCK-1:0];
  assign co = c[BLOCK];
  assign cm = c[BLOCK-1];
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input logic                  clock,
  input logic                  reset_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int SD = (STAGES < 1) ? 1 : STAGES;
  localparam int C  = WIDTH / SD;   // result bits per stage
  localparam int NB = C / BLOCK;    // lookahead groups per stage
  localparam int L  = SD - 1;       // index of the final stage

  if (STAGES < 1 || (WIDTH % (SD * BLOCK)) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: need STAGES >= 1 and WIDTH a multiple of STAGES*BLOCK");
  end

  // Stage registers (index k = output register of stage k)
  logic [SD:1]      vld_pipe;
  logic [WIDTH-1:0] a_q  [SD];
  logic [WIDTH-1:0] b_q  [SD];
  logic [WIDTH-1:0] s_q  [SD];
  logic             cr_q [SD];
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  // Stage inputs and combinational results
  logic [WIDTH-1:0] op_a  [SD];
  logic [WIDTH-1:0] op_b  [SD];
  logic [WIDTH-1:0] ps    [SD];
  logic [WIDTH-1:0] nsum  [SD];
  logic             cin_s [SD];
  logic [SD-1:0]    stg_in_v;
  logic [SD-1:0]    adv;
  wire  [C-1:0]     sl_s  [SD];
  wire  [NB:0]      gc    [SD];
  wire  [NB-1:0]    gm    [SD];

  // Stage sources: stage 0 takes the bus with subtract folded into B/carry-in,
  // later stages take the previous stage's registers
  always_comb begin
    op_a[0]     = bus.x;
    op_b[0]     = bus.sub ? ~bus.y : bus.y;
    cin_s[0]    = bus.sub | bus.c0;
    ps[0]       = '0;
    stg_in_v[0] = bus.in_valid;
    for (int k = 1; k < SD; k++) begin
      op_a[k]     = a_q[k-1];
      op_b[k]     = b_q[k-1];
      cin_s[k]    = cr_q[k-1];
      ps[k]       = s_q[k-1];
      stg_in_v[k] = vld_pipe[k];
    end
  end

  // Stall chain: a stage moves when it is empty or its successor moves
  always_comb begin
    adv    = '0;
    adv[L] = ~vld_pipe[SD] | bus.out_ready;
    for (int k = L - 1; k >= 0; k--)
      adv[k] = ~vld_pipe[k+1] | adv[k+1];
  end

  for (genvar k = 0; k < SD; k++) begin : g_stg
    assign gc[k][0] = cin_s[k];
    for (genvar gi = 0; gi < NB; gi++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a  (op_a[k][k*C + gi*BLOCK +: BLOCK]),
        .b  (op_b[k][k*C + gi*BLOCK +: BLOCK]),
        .ci (gc[k][gi]),
        .s  (sl_s[k][gi*BLOCK +: BLOCK]),
        .co (gc[k][gi+1]),
        .cm (gm[k][gi])
      );
    end
  end

  // Merge each stage's freshly computed slice into the partial sum it carries
  always_comb begin
    for (int k = 0; k < SD; k++) begin
      nsum[k]            = ps[k];
      nsum[k][k*C +: C]  = sl_s[k];
    end
  end

  // Stage registers: load only when the stage advances and its source holds an op
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      for (int k = 0; k < SD; k++) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        s_q[k]  <= '0;
        cr_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SD; k++) begin
        if (adv[k])
          vld_pipe[k+1] <= stg_in_v[k];
        if (adv[k] && stg_in_v[k]) begin
          a_q[k]  <= op_a[k];
          b_q[k]  <= op_b[k];
          s_q[k]  <= nsum[k];
          cr_q[k] <= gc[k][NB];
        end
      end
      if (adv[L] && stg_in_v[L]) begin
        ovf_q  <= gc[L][NB] ^ gm[L][NB-1];
        zero_q <= (nsum[L] == '0);
        neg_q  <= nsum[L][WIDTH-1];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_pipe[SD];
  assign bus.sum       = s_q[L];
  assign bus.Cout      = cr_q[L];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and randomized checks of pipelined_cla_adder in three configurations.
module tb_pipelined_cla_adder;
  localparam int NOPS = 1000;
  localparam int S16  = 1;
  localparam int S64  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [65:0] exp_q [0:NOPS-1];

  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(32)) i32 ();
  pipelined_cla_adder_if #(.WIDTH(16)) i16 ();
  pipelined_cla_adder_if #(.WIDTH(64)) i64 ();

  pipelined_cla_adder #(.WIDTH(32), .STAGES(2),   .BLOCK(4)) u32 (.clock(clk), .reset_n(rst_n), .bus(i32.slave));
  pipelined_cla_adder #(.WIDTH(16), .STAGES(S16), .BLOCK(4)) u16 (.clock(clk), .reset_n(rst_n), .bus(i16.slave));
  pipelined_cla_adder #(.WIDTH(64), .STAGES(S64), .BLOCK(4)) u64 (.clock(clk), .reset_n(rst_n), .bus(i64.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic s);
    logic [63:0] mask, bb, sm;
    logic [64:0] t;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = (s ? ~b : b) & mask;
    t    = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (s | ci)};
    sm   = t[63:0] & mask;
    co   = t[w];
    ov   = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
    return {ov, co, sm};
  endfunction

  // One isolated op on the 32-bit/2-stage unit; call at a falling edge
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b, input logic ci,
                      input logic s, input logic [31:0] e_sum, input logic e_cout, input logic e_ovf,
                      input logic e_zero, input logic e_neg);
    i32.x = a; i32.y = b; i32.c0 = ci; i32.sub = s;
    i32.in_valid = 1'b1; i32.out_ready = 1'b1;
    #1 chk({tag, "/in_ready"}, i32.in_ready, 64'd1);
    @(posedge clk); @(negedge clk);
    i32.in_valid = 1'b0;
    #1 chk({tag, "/valid_c1"}, i32.out_valid, 64'd0);
    @(posedge clk); @(negedge clk); #1;
    chk({tag, "/valid_c2"}, i32.out_valid, 64'd1);
    chk({tag, "/sum"},  i32.sum,  e_sum);
    chk({tag, "/Cout"}, i32.Cout, e_cout);
    chk({tag, "/ovf"},  i32.ovf,  e_ovf);
    chk({tag, "/zero"}, i32.zero, e_zero);
    chk({tag, "/neg"},  i32.neg,  e_neg);
    @(posedge clk); @(negedge clk); #1;
    chk({tag, "/drained"}, i32.out_valid, 64'd0);
    @(negedge clk);
  endtask

  initial begin : main
    int          sent, got, idx;
    logic        acc, cons, rc, rs;
    logic [63:0] ra, rb;

    i32.in_valid = 0; i32.x = '0; i32.y = '0; i32.c0 = 0; i32.sub = 0; i32.out_ready = 0;
    i16.in_valid = 0; i16.x = '0; i16.y = '0; i16.c0 = 0; i16.sub = 0; i16.out_ready = 1;
    i64.in_valid = 0; i64.x = '0; i64.y = '0; i64.c0 = 0; i64.sub = 0; i64.out_ready = 1;

    #2;
    chk("rst/out_valid", i32.out_valid, 64'd0);
    chk("rst/sum",       i32.sum,       64'd0);
    chk("rst/Cout",      i32.Cout,      64'd0);
    chk("rst/ovf",       i32.ovf,       64'd0);
    chk("rst/zero",      i32.zero,      64'd0);
    chk("rst/neg",       i32.neg,       64'd0);
    chk("rst/in_ready",  i32.in_ready,  64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    //              tag        x             y             c0 sub sum           Co ov ze ng
    op32("add_big",  32'h00800000, 32'h00800000, 0, 0, 32'h01000000, 0, 0, 0, 0);
    op32("stg_cross",32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0, 0, 0);
    op32("carry_in", 32'h00000001, 32'h00000002, 1, 0, 32'h00000004, 0, 0, 0, 0);
    op32("wrap",     32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1, 0);
    op32("pos_ovf",  32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0, 1);
    op32("neg_ovf",  32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1, 0);
    op32("sub_neg",  32'h00000005, 32'h00000007, 1, 1, 32'hFFFFFFFE, 0, 0, 0, 1);
    op32("sub_pos",  32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0, 0, 0);
    op32("sub_ovf",  32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0, 0);

    // Stream 6 ops, consumer stalls in cycles 3..5
    sent = 0; got = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      i32.out_ready = !(cyc >= 3 && cyc <= 5);
      i32.in_valid  = (sent < 6);
      i32.x = 32'(sent + 1); i32.y = 32'(3 * (sent + 1)); i32.c0 = 0; i32.sub = 0;
      #1;
      if (sent < 6) chk("stall/in_ready", i32.in_ready, (cyc >= 3 && cyc <= 5) ? 64'd0 : 64'd1);
      if (!i32.out_ready) begin
        chk("stall/hold_valid", i32.out_valid, 64'd1);
        chk("stall/hold_sum",   i32.sum,       64'd4);
      end
      acc  = i32.in_valid && i32.in_ready;
      cons = i32.out_valid && i32.out_ready;
      if (cons) begin
        chk("stall/order", i32.sum, 64'(4 * (got + 1)));
        chk("stall/cycle", 64'(cyc), 64'(6 + got));
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    chk("stall/count", 64'(got), 64'd6);
    i32.in_valid = 0;

    // Reset with two ops in flight
    i32.out_ready = 0; i32.in_valid = 1; i32.x = 32'd10; i32.y = 32'd10;
    @(posedge clk); @(negedge clk);
    i32.x = 32'd20; i32.y = 32'd20;
    @(posedge clk); @(negedge clk);
    i32.in_valid = 0;
    #1 chk("rstmid/pre_valid", i32.out_valid, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid/valid",    i32.out_valid, 64'd0);
    chk("rstmid/sum",      i32.sum,       64'd0);
    chk("rstmid/in_ready", i32.in_ready,  64'd1);
    @(negedge clk); rst_n = 1'b1; i32.out_ready = 1;
    repeat (4) begin
      @(negedge clk);
      #1 chk("rstmid/no_stale", i32.out_valid, 64'd0);
    end
    @(negedge clk);
    op32("after_rst", 32'd3, 32'd4, 0, 0, 32'd7, 0, 0, 0, 0);

    // Random sweep, WIDTH=16 / STAGES=1
    for (int e = 0; e <= NOPS + S16 - 2; e++) begin
      if (e < NOPS) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        i16.x = ra[15:0]; i16.y = rb[15:0]; i16.c0 = rc; i16.sub = rs; i16.in_valid = 1;
        exp_q[e] = ref_add(16, {48'd0, ra[15:0]}, {48'd0, rb[15:0]}, rc, rs);
      end else i16.in_valid = 0;
      @(posedge clk); @(negedge clk); #1;
      idx = e - S16 + 1;
      if (idx < 0) chk("w16/latency", i16.out_valid, 64'd0);
      else begin
        chk("w16/valid", i16.out_valid, 64'd1);
        chk("w16/sum",   i16.sum,       exp_q[idx][63:0]);
        chk("w16/Cout",  i16.Cout,      64'(exp_q[idx][64]));
        chk("w16/ovf",   i16.ovf,       64'(exp_q[idx][65]));
      end
    end
    i16.in_valid = 0;

    // Random sweep, WIDTH=64 / STAGES=4
    for (int e = 0; e <= NOPS + S64 - 2; e++) begin
      if (e < NOPS) begin
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
        i64.x = ra; i64.y = rb; i64.c0 = rc; i64.sub = rs; i64.in_valid = 1;
        exp_q[e] = ref_add(64, ra, rb, rc, rs);
      end else i64.in_valid = 0;
      @(posedge clk); @(negedge clk); #1;
      idx = e - S64 + 1;
      if (idx < 0) chk("w64/latency", i64.out_valid, 64'd0);
      else begin
        chk("w64/valid", i64.out_valid, 64'd1);
        chk("w64/sum",   i64.sum,       exp_q[idx][63:0]);
        chk("w64/Cout",  i64.Cout,      64'(exp_q[idx][64]));
        chk("w64/ovf",   i64.ovf,       64'(exp_q[idx][65]));
      end
    end
    i64.in_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
